// File: rtl/frame_unpacker.sv
// frame_unpacker: pops 128-bit frames from a FIFO and emits the mask-selected 16-bit words in slot order.
module frame_unpacker #(
  parameter int HOLDOFF_CYCLES = 6
) (
  input  logic         read_clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [7:0]   chan_mask,
  input  logic         fifo_ready,
  output logic         frame_pop,
  input  logic [127:0] frame_data_in,
  output logic [15:0]  word_data,
  output logic [2:0]   word_index,
  output logic         word_valid,
  output logic         word_last,
  input  logic         word_ready,
  output logic [15:0]  frame_count,
  output logic         busy
);
  typedef enum logic [2:0] {IDLE, POP, CAPTURE, SEND, HOLDOFF} state_t;
  state_t state, state_nx;
  logic fifo_ready_meta, ready_s;
  logic [127:0] frame_reg;
  logic [7:0] mask_reg, mask_above;
  logic [2:0] idx;
  logic [7:0] hold_cnt;
  function automatic logic [2:0] lowest(input logic [7:0] m);
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--) if (m[i]) lowest = 3'(i);
  endfunction
  // captured-mask bits strictly above the current slot
  assign mask_above = mask_reg & ~((8'd2 << idx) - 8'd1);
  assign word_valid = state == SEND;
  assign word_last = word_valid && mask_above == 8'd0;
  assign word_data = word_valid ? frame_reg[{idx, 4'b0} +: 16] : 16'd0;
  assign word_index = word_valid ? idx : 3'd0;
  assign frame_pop = state == POP;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (enable && ready_s) ? POP : IDLE;
      POP:     state_nx = CAPTURE;
      CAPTURE: state_nx = (chan_mask == 8'd0) ? HOLDOFF : SEND;
      SEND:    state_nx = (word_ready && word_last) ? HOLDOFF : SEND;
      HOLDOFF: state_nx = (hold_cnt == 8'd1) ? IDLE : HOLDOFF;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge read_clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge read_clk) begin
    if (reset) begin
      fifo_ready_meta <= 1'b0;
      ready_s <= 1'b0;
      frame_reg <= '0;
      mask_reg <= 8'd0;
      idx <= 3'd0;
      hold_cnt <= 8'd0;
      frame_count <= 16'd0;
    end else begin
      fifo_ready_meta <= fifo_ready;
      ready_s <= fifo_ready_meta;
      if (state == CAPTURE) begin
        frame_reg <= frame_data_in;
        mask_reg <= chan_mask;
        idx <= lowest(chan_mask);
      end
      if (state == SEND && word_ready && !word_last) idx <= lowest(mask_above);
      if ((state == CAPTURE && chan_mask == 8'd0) || (state == SEND && word_ready && word_last))
        frame_count <= frame_count + 16'd1;
      if (state != HOLDOFF && state_nx == HOLDOFF) hold_cnt <= 8'(HOLDOFF_CYCLES);
      else if (state == HOLDOFF) hold_cnt <= hold_cnt - 8'd1;
    end
  end
endmodule

// File: doc/frame_unpacker.md
FRAME_UNPACKER -- requirements
Module: frame_unpacker

Interface
REQ-001 SHALL have parameter HOLDOFF_CYCLES, default 6: idle cycles after each frame before fifo_ready is re-evaluated (range 4..255).
REQ-002 SHALL have port read_clk, input, 1: sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-004 SHALL have port enable, input, 1: permits starting a new frame.
REQ-005 SHALL have port chan_mask, input, 8: bit k=1 emits word k (frame bits 16k+15:16k).
REQ-006 SHALL have port fifo_ready, input, 1: frame-available flag from the sample_clk domain (asynchronous).
REQ-007 SHALL have port frame_pop, output, 1: one-cycle frame read request to the frame FIFO.
REQ-008 SHALL have port frame_data_in, input, 128: frame from the FIFO, valid the cycle after frame_pop.
REQ-009 SHALL have port word_data, output, 16: current emitted word.
REQ-010 SHALL have port word_index, output, 3: slot number of word_data within its frame.
REQ-011 SHALL have port word_valid, output, 1: word_data/word_index/word_last valid.
REQ-012 SHALL have port word_last, output, 1: current word is the last enabled word of the frame.
REQ-013 SHALL have port word_ready, input, 1: downstream accepts the word when high with word_valid.
REQ-014 SHALL have port frame_count, output, 16: frames consumed since reset, wraps 0xFFFF->0.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-016 SHALL synchronize fifo_ready through two flops (ready_s) before any use.
REQ-017 SHALL implement states IDLE, POP, CAPTURE, SEND, HOLDOFF.
REQ-018 IDLE: enable=1 and ready_s=1 -> POP next cycle; otherwise remain.
REQ-019 POP: frame_pop=1 for exactly this cycle -> CAPTURE; frame_pop SHALL be 0 in all other states.
REQ-020 CAPTURE: register frame_data_in (128 b) and chan_mask; select lowest set mask bit -> SEND; if mask=0, frame is discarded, frame_count increments -> HOLDOFF.
REQ-021 SEND: word_valid=1; word_data=frame_reg[16*idx+15:16*idx]; word_index=idx; word_last=1 iff no set captured-mask bit above idx.
REQ-022 Outputs in SEND SHALL stay stable while word_valid=1 and word_ready=0 (no timeout).
REQ-023 On word_valid&word_ready: non-last -> idx moves to next set mask bit (higher index, skipped slots take no cycles); last -> frame_count+1, -> HOLDOFF.
REQ-024 HOLDOFF: load counter with HOLDOFF_CYCLES on entry; decrement per cycle; -> IDLE when counter reaches 1 (exactly HOLDOFF_CYCLES cycles in HOLDOFF); guarantees frame_pop low long enough for far-domain edge detection and ready_s to reflect the pop.
REQ-025 enable and chan_mask changes SHALL NOT affect a frame already past IDLE; enable=0 only blocks the IDLE->POP transition.
REQ-026 word_valid, word_last SHALL be 0 outside SEND; word_data, word_index SHALL be 0 outside SEND.
REQ-027 Minimum frame period SHALL be 3 + N_enabled + HOLDOFF_CYCLES cycles with word_ready held 1.
REQ-028 frame_count SHALL count each captured frame once, including mask=0 discards.

Reset
REQ-029 While reset=1 at a clock edge: state=IDLE, sync flops=0, frame_pop=0, word_valid=0, word_last=0, word_data=0, word_index=0, frame_count=0, busy=0, holdoff counter=0, frame_reg=0.
REQ-030 Reset asserted in any state (including mid-SEND with word stalled) SHALL abandon the frame without emitting further words or incrementing frame_count.
REQ-031 First possible frame_pop after reset release SHALL be no earlier than 3 cycles after release (2 sync + IDLE decision).

Verification
REQ-032 mask=0xFF, frame=0x0007..0000 words (word k=k), word_ready=1, fifo_ready=1 -> one frame_pop pulse, 8 words idx 0..7 data 0..7 consecutive cycles, word_last only on idx 7, frame_count=1.
REQ-033 mask=0x24 -> exactly 2 words, idx 2 then idx 5, word_last on idx 5; mask=0x00 -> no word_valid, frame_count still increments.
REQ-034 word_ready low 5 cycles on idx 3 -> word_valid/data/idx held constant 5 cycles, then progression resumes at idx 4.
REQ-035 fifo_ready held 1 continuously -> successive frame_pop pulses separated by exactly 3+N_enabled+HOLDOFF_CYCLES-1 low cycles; frame_pop never high two consecutive cycles.
REQ-036 reset pulsed during SEND idx 4 -> next cycle all outputs per REQ-029, frame_count=0; enable=0 mid-frame -> frame completes, no further frame_pop.
REQ-037 frame_count preset near wrap via 65536 frames (or forced) -> 0xFFFF then 0x0000.
